// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Tracks every in-flight register write in the stages after decode and
// produces stall/flush controls plus registered forward-source selects for
// the scalar and vector register files.
// Tracker entry 0 is E, entry 1 is M, entry 2 is W, and so on.
//
// Ports
//   clk         pipeline clock
//   rst         synchronous, active-low reset
//   valid_d     decode holds a real instruction
//   rs1_d/rs2_d source addresses; *_vec_d selects the vector file;
//               *_use_d marks a source that is actually read
//   rd_d        destination address; rd_vec_d selects the vector file
//   we_d        instruction writes a register
//   lat_d       cycles from entering E until forwardable
//               (0 behaves as 1, values above MAX_LAT are clamped)
//   pc_src_e    taken branch/jump resolved in E
//   stall_f     hold PC
//   stall_d     hold F/D register
//   flush_d     clear F/D register
//   flush_e     clear D/E register
//   fwd_a_e     source-1 forward select for the instruction in E
//               (0 = register file, k = tracker entry k)
//   fwd_b_e     same, for source 2
//
// Optional build macro HAZARD_PERF_CNT_EN adds:
//   stall_cnt   cycles with stall_d = 1 (wraps at 2^32)
//   flush_cnt   cycles with pc_src_e = 1 (wraps at 2^32)
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int STAGES  = 3,
    parameter int REG_AW  = 5,
    parameter int MAX_LAT = 4,
    parameter int SEL_W   = $clog2(STAGES + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_d,
    input  logic [REG_AW-1:0]              rs1_d,
    input  logic [REG_AW-1:0]              rs2_d,
    input  logic                           rs1_vec_d,
    input  logic                           rs2_vec_d,
    input  logic                           rs1_use_d,
    input  logic                           rs2_use_d,
    input  logic [REG_AW-1:0]              rd_d,
    input  logic                           rd_vec_d,
    input  logic                           we_d,
    input  logic [$clog2(MAX_LAT+1)-1:0]   lat_d,
    input  logic                           pc_src_e,
    output logic                           stall_f,
    output logic                           stall_d,
    output logic                           flush_d,
    output logic                           flush_e,
    output logic [SEL_W-1:0]               fwd_a_e,
    output logic [SEL_W-1:0]               fwd_b_e
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                    stall_cnt,
    output logic [31:0]                    flush_cnt
`endif
);

    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_MAX_V = LAT_W'(MAX_LAT);

    // Tracker entries. cnt holds lat-1 at load and counts down each edge,
    // so a nonzero cnt means the result is not yet forwardable to the
    // instruction currently in decode.
    logic              trk_valid_q [STAGES];
    logic              trk_we_q    [STAGES];
    logic [REG_AW-1:0] trk_rd_q    [STAGES];
    logic              trk_vec_q   [STAGES];
    logic [LAT_W-1:0]  trk_cnt_q   [STAGES];

    logic              trk_valid_d [STAGES];
    logic              trk_we_d    [STAGES];
    logic [REG_AW-1:0] trk_rd_d    [STAGES];
    logic              trk_vec_d   [STAGES];
    logic [LAT_W-1:0]  trk_cnt_d   [STAGES];

    logic [SEL_W-1:0]  fwd_a_q, fwd_a_d;
    logic [SEL_W-1:0]  fwd_b_q, fwd_b_d;

    logic [STAGES-1:0] match_a, match_b;
    logic              haz_a, haz_b, hazard;
    logic [SEL_W-1:0]  fwd_a_nxt, fwd_b_nxt;
    logic [LAT_W-1:0]  lat_eff;
    logic              flush_any;
    logic              advance;

    // Source/entry match. Scalar x0 is hard-wired and never matches;
    // vector v0 is a real register.
    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 0; k < STAGES; k++) begin
            match_a[k] = rs1_use_d && trk_valid_q[k] && trk_we_q[k]
                         && (trk_rd_q[k] == rs1_d) && (trk_vec_q[k] == rs1_vec_d)
                         && (rs1_vec_d || (rs1_d != '0));
            match_b[k] = rs2_use_d && trk_valid_q[k] && trk_we_q[k]
                         && (trk_rd_q[k] == rs2_d) && (trk_vec_q[k] == rs2_vec_d)
                         && (rs2_vec_d || (rs2_d != '0));
        end
    end

    // Youngest match wins: scan from oldest to youngest so the lowest
    // index overwrites. The select names the entry the producer will
    // occupy after the next edge; past the last entry it has retired and
    // the write-through register file supplies the value.
    always_comb begin
        haz_a     = 1'b0;
        haz_b     = 1'b0;
        fwd_a_nxt = '0;
        fwd_b_nxt = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (match_a[k]) begin
                haz_a     = (trk_cnt_q[k] != '0);
                fwd_a_nxt = (k + 1 < STAGES) ? SEL_W'(k + 1) : '0;
            end
            if (match_b[k]) begin
                haz_b     = (trk_cnt_q[k] != '0);
                fwd_b_nxt = (k + 1 < STAGES) ? SEL_W'(k + 1) : '0;
            end
        end
    end

    assign hazard = haz_a || haz_b;

    // Reset and branch flush both take priority over a hazard stall.
    assign flush_any = !rst || pc_src_e;
    assign stall_d   = !flush_any && hazard;
    assign stall_f   = stall_d;
    assign flush_d   = flush_any;
    assign flush_e   = flush_any || hazard;
    assign advance   = valid_d && !stall_d && !flush_e;

    always_comb begin
        lat_eff = lat_d;
        if (lat_d == '0) begin
            lat_eff = LAT_ONE;
        end else if (lat_d > LAT_MAX_V) begin
            lat_eff = LAT_MAX_V;
        end
    end

    always_comb begin
        for (int k = 1; k < STAGES; k++) begin
            trk_valid_d[k] = trk_valid_q[k-1];
            trk_we_d[k]    = trk_we_q[k-1];
            trk_rd_d[k]    = trk_rd_q[k-1];
            trk_vec_d[k]   = trk_vec_q[k-1];
            trk_cnt_d[k]   = (trk_cnt_q[k-1] == '0) ? '0 : trk_cnt_q[k-1] - LAT_ONE;
        end
        trk_valid_d[0] = advance;
        trk_we_d[0]    = advance && we_d;
        trk_rd_d[0]    = advance ? rd_d : '0;
        trk_vec_d[0]   = advance && rd_vec_d;
        trk_cnt_d[0]   = advance ? (lat_eff - LAT_ONE) : '0;

        fwd_a_d = advance ? fwd_a_nxt : '0;
        fwd_b_d = advance ? fwd_b_nxt : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                trk_valid_q[k] <= 1'b0;
                trk_we_q[k]    <= 1'b0;
                trk_rd_q[k]    <= '0;
                trk_vec_q[k]   <= 1'b0;
                trk_cnt_q[k]   <= '0;
            end
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                trk_valid_q[k] <= trk_valid_d[k];
                trk_we_q[k]    <= trk_we_d[k];
                trk_rd_q[k]    <= trk_rd_d[k];
                trk_vec_q[k]   <= trk_vec_d[k];
                trk_cnt_q[k]   <= trk_cnt_d[k];
            end
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_e = fwd_a_q;
    assign fwd_b_e = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_d  ? stall_cnt_q + 32'd1 : stall_cnt_q;
        flush_cnt_d = pc_src_e ? flush_cnt_q + 32'd1 : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int STAGES  = 5;
    localparam int REG_AW  = 5;
    localparam int MAX_LAT = 4;
    localparam int SEL_W   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_d;
    logic [4:0]       rs1_d, rs2_d, rd_d;
    logic             rs1_vec_d, rs2_vec_d, rs1_use_d, rs2_use_d;
    logic             rd_vec_d, we_d;
    logic [2:0]       lat_d;
    logic             pc_src_e;
    logic             stall_f, stall_d, flush_d, flush_e;
    logic [2:0]       fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]      stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .STAGES (STAGES),
        .REG_AW (REG_AW),
        .MAX_LAT(MAX_LAT),
        .SEL_W  (SEL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_d  (valid_d),
        .rs1_d    (rs1_d),
        .rs2_d    (rs2_d),
        .rs1_vec_d(rs1_vec_d),
        .rs2_vec_d(rs2_vec_d),
        .rs1_use_d(rs1_use_d),
        .rs2_use_d(rs2_use_d),
        .rd_d     (rd_d),
        .rd_vec_d (rd_vec_d),
        .we_d     (we_d),
        .lat_d    (lat_d),
        .pc_src_e (pc_src_e),
        .stall_f  (stall_f),
        .stall_d  (stall_d),
        .flush_d  (flush_d),
        .flush_e  (flush_e),
        .fwd_a_e  (fwd_a_e),
        .fwd_b_e  (fwd_b_e)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] rs1;
        logic       r1v;
        logic       u1;
        logic [4:0] rs2;
        logic       r2v;
        logic       u2;
        logic [4:0] rd;
        logic       rdv;
        logic       we;
        logic [2:0] lat;
        logic       pc;
        logic       e_st;
        logic       e_fd;
        logic       e_fe;
        logic [2:0] e_fa;
        logic [2:0] e_fb;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic v,
        input int a1, input logic a1v, input logic u1,
        input int a2, input logic a2v, input logic u2,
        input int d, input logic dv, input logic w, input int lat, input logic pc,
        input logic est, input logic efd, input logic efe, input int efa, input int efb);
        vec_t t;
        t.rst = r;   t.v = v;
        t.rs1 = 5'(a1); t.r1v = a1v; t.u1 = u1;
        t.rs2 = 5'(a2); t.r2v = a2v; t.u2 = u2;
        t.rd  = 5'(d);  t.rdv = dv;  t.we = w;
        t.lat = 3'(lat); t.pc = pc;
        t.e_st = est; t.e_fd = efd; t.e_fe = efe;
        t.e_fa = 3'(efa); t.e_fb = 3'(efb);
        return t;
    endfunction

    // Inputs are driven just after the falling edge, outputs sampled 1 ns
    // later; the following rising edge consumes the inputs.
    task automatic run_vec(input vec_t t, input string tag);
        @(negedge clk);
        rst       = t.rst;
        valid_d   = t.v;
        rs1_d     = t.rs1;  rs1_vec_d = t.r1v; rs1_use_d = t.u1;
        rs2_d     = t.rs2;  rs2_vec_d = t.r2v; rs2_use_d = t.u2;
        rd_d      = t.rd;   rd_vec_d  = t.rdv; we_d      = t.we;
        lat_d     = t.lat;
        pc_src_e  = t.pc;
        #1;
        n_checks++;
        if ({stall_f, stall_d, flush_d, flush_e} !== {t.e_st, t.e_st, t.e_fd, t.e_fe}
            || fwd_a_e !== t.e_fa || fwd_b_e !== t.e_fb) begin
            n_errors++;
            $display("FAIL %s: got sf=%b sd=%b fd=%b fe=%b fa=%0d fb=%0d, want sf=%b sd=%b fd=%b fe=%b fa=%0d fb=%0d",
                     tag, stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e,
                     t.e_st, t.e_st, t.e_fd, t.e_fe, t.e_fa, t.e_fb);
        end
    endtask

    vec_t tv[$];
    vec_t hs[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // args: rst v | rs1 vec use | rs2 vec use | rd vec we lat pc | exp stall fd fe fa fb
        // reset held with a live instruction in decode
        tv.push_back(mk(0,1,  5,0,1,  0,0,0,  5,0,1, 1,0,  0,1,1, 0,0));
        tv.push_back(mk(0,1,  5,0,1,  0,0,0,  5,0,1, 1,0,  0,1,1, 0,0));
        tv.push_back(mk(0,1,  5,0,1,  0,0,0,  5,0,1, 1,0,  0,1,1, 0,0));
        tv.push_back(mk(1,0,  0,0,0,  0,0,0,  0,0,0, 0,0,  0,0,0, 0,0));
        // back-to-back ALU on x5
        tv.push_back(mk(1,1,  0,0,0,  0,0,0,  5,0,1, 1,0,  0,0,0, 0,0));
        tv.push_back(mk(1,1,  5,0,1,  0,0,0,  8,0,1, 1,0,  0,0,0, 0,0));
        tv.push_back(mk(1,0,  0,0,0,  0,0,0,  0,0,0, 0,0,  0,0,0, 1,0));
        // load-use on x6 via rs2
        tv.push_back(mk(1,1,  0,0,0,  0,0,0,  6,0,1, 2,0,  0,0,0, 0,0));
        tv.push_back(mk(1,1,  1,0,1,  6,0,1,  9,0,1, 1,0,  1,0,1, 0,0));
        tv.push_back(mk(1,1,  1,0,1,  6,0,1,  9,0,1, 1,0,  0,0,0, 0,0));
        tv.push_back(mk(1,0,  0,0,0,  0,0,0,  0,0,0, 0,0,  0,0,0, 0,2));
        // vector v3 latency 4 -> three stalls, then forward from entry 4
        tv.push_back(mk(1,1,  0,0,0,  0,0,0,  3,1,1, 4,0,  0,0,0, 0,0));
        tv.push_back(mk(1,1,  3,1,1,  0,0,0,  4,1,1, 1,0,  1,0,1, 0,0));
        tv.push_back(mk(1,1,  3,1,1,  0,0,0,  4,1,1, 1,0,  1,0,1, 0,0));
        tv.push_back(mk(1,1,  3,1,1,  0,0,0,  4,1,1, 1,0,  1,0,1, 0,0));
        tv.push_back(mk(1,1,  3,1,1,  0,0,0,  4,1,1, 1,0,  0,0,0, 0,0));
        // scalar x3 read right behind a fresh v3 producer: no stall
        tv.push_back(mk(1,1,  0,0,0,  0,0,0,  3,1,1, 4,0,  0,0,0, 4,0));
        tv.push_back(mk(1,1,  3,0,1,  0,0,0,  0,0,0, 1,0,  0,0,0, 0,0));
        // branch resolves while a load-use stall is active
        tv.push_back(mk(1,1,  0,0,0,  0,0,0, 10,0,1, 3,0,  0,0,0, 0,0));
        tv.push_back(mk(1,1, 10,0,1,  0,0,0, 11,0,1, 1,0,  1,0,1, 0,0));
        tv.push_back(mk(1,1, 10,0,1,  0,0,0, 11,0,1, 1,1,  0,1,1, 0,0));
        tv.push_back(mk(1,0,  0,0,0,  0,0,0,  0,0,0, 0,0,  0,0,0, 0,0));
        // two writers of x7: youngest (entry 0) wins
        tv.push_back(mk(1,1,  0,0,0,  0,0,0,  7,0,1, 1,0,  0,0,0, 0,0));
        tv.push_back(mk(1,1,  0,0,0,  0,0,0,  7,0,1, 1,0,  0,0,0, 0,0));
        tv.push_back(mk(1,1,  7,0,1,  7,0,1,  0,0,0, 1,0,  0,0,0, 0,0));
        // write to x0 then read x0: never matches
        tv.push_back(mk(1,1,  0,0,0,  0,0,0,  0,0,1, 3,0,  0,0,0, 1,1));
        tv.push_back(mk(1,1,  0,0,1,  0,0,1,  0,0,0, 1,0,  0,0,0, 0,0));
        tv.push_back(mk(1,0,  0,0,0,  0,0,0,  0,0,0, 0,0,  0,0,0, 0,0));
        // vector v0 is a real register
        tv.push_back(mk(1,1,  0,0,0,  0,0,0,  0,1,1, 2,0,  0,0,0, 0,0));
        tv.push_back(mk(1,1,  0,0,0,  0,1,1,  0,0,0, 1,0,  1,0,1, 0,0));
        tv.push_back(mk(1,1,  0,0,0,  0,1,1,  0,0,0, 1,0,  0,0,0, 0,0));
        tv.push_back(mk(1,0,  0,0,0,  0,0,0,  0,0,0, 0,0,  0,0,0, 0,2));
        // lat 0 behaves as 1, lat 7 clamps to 4
        tv.push_back(mk(1,1,  0,0,0,  0,0,0, 12,0,1, 0,0,  0,0,0, 0,0));
        tv.push_back(mk(1,1, 12,0,1,  0,0,0, 13,0,1, 7,0,  0,0,0, 0,0));
        tv.push_back(mk(1,1,  0,0,0, 13,0,1,  0,0,0, 1,0,  1,0,1, 1,0));
        tv.push_back(mk(1,1,  0,0,0, 13,0,1,  0,0,0, 1,0,  1,0,1, 0,0));
        tv.push_back(mk(1,1,  0,0,0, 13,0,1,  0,0,0, 1,0,  1,0,1, 0,0));
        tv.push_back(mk(1,1,  0,0,0, 13,0,1,  0,0,0, 1,0,  0,0,0, 0,0));
        tv.push_back(mk(1,0,  0,0,0,  0,0,0,  0,0,0, 0,0,  0,0,0, 0,4));

        // reset asserted in the middle of a stall discards the producer
        hs.push_back(mk(1,1,  0,0,0,  0,0,0, 14,0,1, 4,0,  0,0,0, 0,0));
        hs.push_back(mk(1,1, 14,0,1,  0,0,0,  0,0,0, 1,0,  1,0,1, 0,0));
        hs.push_back(mk(0,1, 14,0,1,  0,0,0,  0,0,0, 1,0,  0,1,1, 0,0));
        hs.push_back(mk(1,1, 14,0,1,  0,0,0,  0,0,0, 1,0,  0,0,0, 0,0));
        hs.push_back(mk(1,1, 14,0,1,  0,0,0,  0,0,0, 1,0,  0,0,0, 0,0));

        rst = 1'b0; valid_d = 1'b0;
        rs1_d = '0; rs2_d = '0; rd_d = '0;
        rs1_vec_d = 1'b0; rs2_vec_d = 1'b0; rs1_use_d = 1'b0; rs2_use_d = 1'b0;
        rd_vec_d = 1'b0; we_d = 1'b0; lat_d = '0; pc_src_e = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            run_vec(tv[i], $sformatf("vec%0d", i));
        end
        for (int i = 0; i < hs.size(); i++) begin
            run_vec(hs[i], $sformatf("rst_mid_stall_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
